// File: rtl/safe_entry_controller.sv
// Safe lock front-end: debounces buttons into one-hot key strobes, tracks failed attempts,
// runs a timed lockout with error/seconds LEDs and gates passcode-programming sessions.
module safe_entry_controller #(
   parameter int unsigned TICK_DIV = 50_000_000,
   parameter int unsigned DEB_CYC  = 1_000_000,
   parameter int unsigned MAX_ERR  = 3,
   parameter int unsigned LOCK_SEC = 10,
   parameter int unsigned CODE_LEN = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] btn_n,
   input  logic       ms,
   input  logic       unlocked_in,
   input  logic       attempt_ok,
   input  logic       attempt_fail,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       prog_mode,
   output logic       prog_done,
   output logic       locked_out,
   output logic       lock_clear,
   output logic [2:0] leds_erros,
   output logic [9:0] leds_segundos
);

   localparam int unsigned DW = $clog2(DEB_CYC + 1);
   localparam int unsigned TW = $clog2(TICK_DIV);
   localparam int unsigned EW = 2;
   localparam int unsigned SW = 4;
   localparam int unsigned KW = 4;

   typedef enum logic [1:0] {IDLE, PROG, LOCKOUT} state_e;

   state_e        state_q, state_d;
   logic [3:0]    s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic [3:0]    deb_q, deb_d;
   logic [DW-1:0] deb_cnt_q, deb_cnt_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [SW-1:0] sec_q, sec_d;
   logic [EW-1:0] err_q, err_d;
   logic [KW-1:0] key_cnt_q, key_cnt_d;
   logic [9:0]    leds_seg_q, leds_seg_d;
   logic          key_valid_d, prog_mode_d, prog_done_d, locked_out_d, lock_clear_d;
   logic [3:0]    key_code_d;
   logic          press;

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         s1_q       <= '0;
         s2_q       <= '0;
         s3_q       <= '0;
         deb_q      <= '0;
         deb_cnt_q  <= '0;
         tick_q     <= '0;
         sec_q      <= '0;
         err_q      <= '0;
         key_cnt_q  <= '0;
         leds_seg_q <= '0;
         key_valid  <= 1'b0;
         key_code   <= '0;
         prog_mode  <= 1'b0;
         prog_done  <= 1'b0;
         locked_out <= 1'b0;
         lock_clear <= 1'b0;
      end else begin
         state_q    <= state_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         s3_q       <= s3_d;
         deb_q      <= deb_d;
         deb_cnt_q  <= deb_cnt_d;
         tick_q     <= tick_d;
         sec_q      <= sec_d;
         err_q      <= err_d;
         key_cnt_q  <= key_cnt_d;
         leds_seg_q <= leds_seg_d;
         key_valid  <= key_valid_d;
         key_code   <= key_code_d;
         prog_mode  <= prog_mode_d;
         prog_done  <= prog_done_d;
         locked_out <= locked_out_d;
         lock_clear <= lock_clear_d;
      end
   end

   // Next-state logic: input path, debounce, supervisor FSM
   always_comb begin
      s1_d         = ~btn_n;
      s2_d         = s1_q;
      s3_d         = s2_q;
      deb_d        = deb_q;
      deb_cnt_d    = '0;
      state_d      = state_q;
      tick_d       = tick_q;
      sec_d        = sec_q;
      err_d        = err_q;
      key_cnt_d    = key_cnt_q;
      leds_seg_d   = leds_seg_q;
      prog_done_d  = 1'b0;
      lock_clear_d = 1'b0;

      // s3_q is the previous synchronised sample; any change restarts the count
      if ((s2_q == s3_q) && (s2_q != deb_q)) begin
         if (deb_cnt_q == DW'(DEB_CYC - 1)) deb_d = s2_q;
         else                               deb_cnt_d = deb_cnt_q + 1'b1;
      end
      press = (deb_q == 4'b0000) && $onehot(deb_d);

      case (state_q)
         IDLE: begin
            if (attempt_fail) begin
               err_d = err_q + 1'b1;
               if (err_d == EW'(MAX_ERR)) begin
                  state_d    = LOCKOUT;
                  tick_d     = '0;
                  sec_d      = '0;
                  leds_seg_d = '0;
               end
            end else if (attempt_ok) begin
               err_d = '0;
            end else if (ms && unlocked_in) begin
               state_d   = PROG;
               key_cnt_d = '0;
            end
         end
         PROG: begin
            if (key_valid && (key_cnt_q == KW'(CODE_LEN - 1))) begin
               prog_done_d = 1'b1;
               err_d       = '0;
               key_cnt_d   = '0;
               state_d     = IDLE;
            end else if (!ms) begin
               state_d = IDLE;
            end else if (key_valid) begin
               key_cnt_d = key_cnt_q + 1'b1;
            end
         end
         LOCKOUT: begin
            if (tick_q == TW'(TICK_DIV - 1)) begin
               tick_d            = '0;
               sec_d             = sec_q + 1'b1;
               leds_seg_d[sec_q] = 1'b1;
               if (sec_d == SW'(LOCK_SEC)) begin
                  lock_clear_d = 1'b1;
                  err_d        = '0;
                  leds_seg_d   = '0;
                  state_d      = IDLE;
               end
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Gating on the next state keeps key_valid and locked_out mutually exclusive
      key_valid_d  = press && (state_d != LOCKOUT);
      key_code_d   = key_valid_d ? deb_d : 4'b0000;
      prog_mode_d  = (state_d == PROG);
      locked_out_d = (state_d == LOCKOUT);
   end

   // Thermometer of the registered error count
   always_comb begin
      case (err_q)
         2'd0:    leds_erros = 3'b000;
         2'd1:    leds_erros = 3'b001;
         2'd2:    leds_erros = 3'b011;
         default: leds_erros = 3'b111;
      endcase
   end

   assign leds_segundos = leds_seg_q;

endmodule
